board_update: RTL and testbench

Playfield owner, directly downstream of the falling-piece generator. When the generator reports a landed piece, this block writes its four cells into the 10×12 occupancy array, removes completed rows one at a time, and pulses `gen_flag` to request the next piece. On a top-out it holds the board until `Ack`, then clears the board and restarts. The generator reads `arr` back for its collision checks.

---
 rtl/tetris_pkg.sv | 32 +++
 rtl/board_update_row_full_detect.sv | 19 +
 rtl/board_update.sv | 107 ++++++++++
 tb/tb_board_update.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield geometry, state encoding and board helpers.
package tetris_pkg;

  localparam int unsigned COLS    = 10;
  localparam int unsigned ROWS    = 12;
  localparam int unsigned COORD_W = 4;
  localparam int unsigned STATE_W = 5;
  localparam int unsigned LINES_W = 8;

  typedef enum logic [STATE_W-1:0] {
    START = 5'b00001,
    GEN   = 5'b00010,
    IDLE  = 5'b00100,
    SCAN  = 5'b01000,
    OVER  = 5'b10000
  } state_t;

  typedef logic [COLS-1:0][ROWS-1:0] board_t;

  // Sets one cell; out-of-range coordinates leave the board unchanged.
  function automatic board_t set_cell(input board_t b,
                                      input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
    board_t nb;
    nb = b;
    if ((x < COORD_W'(COLS)) && (y < COORD_W'(ROWS))) begin
      nb[x][y] = 1'b1;
    end
    return nb;
  endfunction

endpackage

// File: rtl/board_update_row_full_detect.sv
// Per-row completeness flags for the playfield.
module row_full_detect
  import tetris_pkg::*;
(
  input  logic [COLS-1:0][ROWS-1:0] arr,
  output logic [ROWS-1:0]           full
);

  // A row is full when every column holds a cell in that row.
  always_comb begin
    full = '1;
    for (int y = 0; y < int'(ROWS); y++) begin
      for (int x = 0; x < int'(COLS); x++) begin
        full[y] = full[y] & arr[x][y];
      end
    end
  end

endmodule

// File: rtl/board_update.sv
// Playfield owner: locks landed pieces, clears full rows, requests new pieces.
module board_update
  import tetris_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      bottom_flag,
  input  logic                      top_flag,
  input  logic                      Ack,
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y1,
  input  logic [COORD_W-1:0]        x2,
  input  logic [COORD_W-1:0]        y2,
  input  logic [COORD_W-1:0]        x3,
  input  logic [COORD_W-1:0]        y3,
  input  logic [COORD_W-1:0]        x4,
  input  logic [COORD_W-1:0]        y4,
  output logic [COLS-1:0][ROWS-1:0] arr,
  output logic                      gen_flag,
  output logic                      game_over,
  output logic [LINES_W-1:0]        lines,
  output logic [STATE_W-1:0]        state
);

  state_t               state_q, state_d;
  board_t               arr_q, arr_d;
  logic [LINES_W-1:0]   lines_q, lines_d;
  logic [COORD_W-1:0]   r_q, r_d;
  logic [ROWS-1:0]      full;

  row_full_detect u_row_full_detect (
    .arr  (arr_q),
    .full (full)
  );

  // State, board, line count and scan row registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= START;
      arr_q   <= '0;
      lines_q <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      lines_q <= lines_d;
      r_q     <= r_d;
    end
  end

  // Next-state logic: piece lock, row-at-a-time clearing, top-out hold.
  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    lines_d = lines_q;
    r_d     = r_q;
    unique case (state_q)
      START: state_d = GEN;
      GEN:   state_d = IDLE;
      IDLE: begin
        if (bottom_flag) begin
          arr_d = set_cell(arr_d, x1, y1);
          arr_d = set_cell(arr_d, x2, y2);
          arr_d = set_cell(arr_d, x3, y3);
          arr_d = set_cell(arr_d, x4, y4);
          r_d   = '0;
          state_d = top_flag ? OVER : SCAN;
        end
      end
      SCAN: begin
        if (full[r_q]) begin
          // Drop everything above row r by one; r stays to recheck the new row.
          for (int x = 0; x < int'(COLS); x++) begin
            for (int y = 0; y < int'(ROWS) - 1; y++) begin
              if (COORD_W'(y) >= r_q) begin
                arr_d[x][y] = arr_q[x][y+1];
              end
            end
            arr_d[x][ROWS-1] = 1'b0;
          end
          if (lines_q != '1) begin
            lines_d = lines_q + LINES_W'(1);
          end
        end else if (r_q == COORD_W'(ROWS - 1)) begin
          state_d = GEN;
        end else begin
          r_d = r_q + COORD_W'(1);
        end
      end
      OVER: begin
        if (Ack) begin
          arr_d   = '0;
          lines_d = '0;
          state_d = START;
        end
      end
      default: state_d = START;
    endcase
  end

  assign arr       = arr_q;
  assign lines     = lines_q;
  assign state     = state_q;
  assign gen_flag  = (state_q == GEN);
  assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_board_update.sv
// Directed self-checking bench for board_update.
module tb_board_update;
  import tetris_pkg::*;

  logic                      Clk;
  logic                      Reset;
  logic                      bottom_flag;
  logic                      top_flag;
  logic                      Ack;
  logic [COORD_W-1:0]        x1, y1, x2, y2, x3, y3, x4, y4;
  logic [COLS-1:0][ROWS-1:0] arr;
  logic                      gen_flag;
  logic                      game_over;
  logic [LINES_W-1:0]        lines;
  logic [STATE_W-1:0]        state;

  int n_cmp = 0;
  int n_bad = 0;

  board_update dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .bottom_flag (bottom_flag),
    .top_flag    (top_flag),
    .Ack         (Ack),
    .x1 (x1), .y1 (y1), .x2 (x2), .y2 (y2),
    .x3 (x3), .y3 (y3), .x4 (x4), .y4 (y4),
    .arr         (arr),
    .gen_flag    (gen_flag),
    .game_over   (game_over),
    .lines       (lines),
    .state       (state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Hold reset for three cycles, release, step into IDLE.
  task automatic do_reset;
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // Present a landing for one IDLE cycle; returns in cycle t+1.
  task automatic land(input logic [3:0] a1, input logic [3:0] b1,
                      input logic [3:0] a2, input logic [3:0] b2,
                      input logic [3:0] a3, input logic [3:0] b3,
                      input logic [3:0] a4, input logic [3:0] b4,
                      input logic top);
    x1 = a1; y1 = b1; x2 = a2; y2 = b2;
    x3 = a3; y3 = b3; x4 = a4; y4 = b4;
    top_flag    = top;
    bottom_flag = 1'b1;
    tick();
    bottom_flag = 1'b0;
    top_flag    = 1'b0;
  endtask

  // Offset from landing cycle t to the gen_flag cycle, then step into IDLE.
  task automatic wait_gen(output int n);
    n = 1;
    while (!gen_flag && n < 60) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    n_cmp++;
    if (gen_flag !== 1'b0 || state !== 5'b00001) begin
      $display("FAIL reset_cycle1: gen_flag=%b state=%b expected 0/00001", gen_flag, state);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (gen_flag !== 1'b1) begin
      $display("FAIL reset_cycle2_gen: gen_flag=%b expected 1", gen_flag);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (gen_flag !== 1'b0 || state !== 5'b00100) begin
      $display("FAIL reset_idle: gen_flag=%b state=%b expected 0/00100", gen_flag, state);
      n_bad++;
    end
    n_cmp++;
    if (arr !== '0 || lines !== 8'd0 || game_over !== 1'b0) begin
      $display("FAIL reset_clear: arr=%h lines=%0d game_over=%b expected 0/0/0", arr, lines, game_over);
      n_bad++;
    end
  endtask

  task automatic test_simple_land;
    board_t exp;
    int     n;
    exp = '0;
    exp[4][0] = 1'b1; exp[5][0] = 1'b1; exp[6][0] = 1'b1; exp[7][0] = 1'b1;
    land(4, 0, 5, 0, 6, 0, 7, 0, 1'b0);
    n_cmp++;
    if (arr !== exp) begin
      $display("FAIL simple_cells_t1: arr=%h expected %h", arr, exp);
      n_bad++;
    end
    wait_gen(n);
    n_cmp++;
    if (n != 13) begin
      $display("FAIL simple_gen_latency: got %0d expected 13", n);
      n_bad++;
    end
    n_cmp++;
    if (arr !== exp || lines !== 8'd0) begin
      $display("FAIL simple_final: arr=%h lines=%0d expected %h/0", arr, lines, exp);
      n_bad++;
    end
  endtask

  task automatic test_ack_ignored;
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    n_cmp++;
    if (state !== 5'b00100) begin
      $display("FAIL ack_in_idle: state=%b expected 00100", state);
      n_bad++;
    end
  endtask

  task automatic test_one_clear;
    board_t exp;
    int     n;
    do_reset();
    land(0, 0, 1, 0, 2, 0, 3, 0, 1'b0);
    wait_gen(n);
    land(4, 0, 5, 0, 5, 1, 5, 1, 1'b0);
    wait_gen(n);
    land(6, 0, 7, 0, 8, 0, 9, 0, 1'b0);
    wait_gen(n);
    exp = '0;
    exp[5][0] = 1'b1;
    n_cmp++;
    if (n != 14) begin
      $display("FAIL one_clear_latency: got %0d expected 14", n);
      n_bad++;
    end
    n_cmp++;
    if (arr !== exp || lines !== 8'd1) begin
      $display("FAIL one_clear_board: arr=%h lines=%0d expected %h/1", arr, lines, exp);
      n_bad++;
    end
  endtask

  task automatic test_two_clear;
    board_t exp;
    int     n;
    do_reset();
    land(0, 0, 1, 0, 2, 0, 3, 0, 1'b0); wait_gen(n);
    land(4, 0, 5, 0, 6, 0, 7, 0, 1'b0); wait_gen(n);
    land(8, 0, 0, 1, 1, 1, 2, 1, 1'b0); wait_gen(n);
    land(3, 1, 4, 1, 5, 1, 6, 1, 1'b0); wait_gen(n);
    land(7, 1, 8, 1, 3, 2, 3, 2, 1'b0); wait_gen(n);
    n_cmp++;
    if (lines !== 8'd0) begin
      $display("FAIL two_clear_preload_lines: got %0d expected 0", lines);
      n_bad++;
    end
    land(9, 0, 9, 1, 8, 2, 8, 3, 1'b0);
    wait_gen(n);
    exp = '0;
    exp[3][0] = 1'b1; exp[8][0] = 1'b1; exp[8][1] = 1'b1;
    n_cmp++;
    if (n != 15) begin
      $display("FAIL two_clear_latency: got %0d expected 15", n);
      n_bad++;
    end
    n_cmp++;
    if (arr !== exp || lines !== 8'd2) begin
      $display("FAIL two_clear_board: arr=%h lines=%0d expected %h/2", arr, lines, exp);
      n_bad++;
    end
  endtask

  task automatic test_top_out;
    board_t exp;
    int     gens;
    do_reset();
    exp = '0;
    exp[0][11] = 1'b1; exp[1][11] = 1'b1; exp[2][11] = 1'b1; exp[3][11] = 1'b1;
    land(0, 11, 1, 11, 2, 11, 3, 11, 1'b1);
    n_cmp++;
    if (arr !== exp || game_over !== 1'b1 || state !== 5'b10000) begin
      $display("FAIL topout_enter: arr=%h game_over=%b state=%b expected %h/1/10000", arr, game_over, state, exp);
      n_bad++;
    end
    gens = 0;
    bottom_flag = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (gen_flag) gens++;
      tick();
    end
    bottom_flag = 1'b0;
    n_cmp++;
    if (gens != 0 || arr !== exp || game_over !== 1'b1) begin
      $display("FAIL topout_hold: gens=%0d arr=%h game_over=%b expected 0/%h/1", gens, arr, exp, game_over);
      n_bad++;
    end
    Ack = 1'b1;
    tick();
    Ack = 1'b0;
    n_cmp++;
    if (arr !== '0 || lines !== 8'd0 || state !== 5'b00001 || game_over !== 1'b0) begin
      $display("FAIL ack_restart: arr=%h lines=%0d state=%b expected 0/0/00001", arr, lines, state);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (gen_flag !== 1'b1) begin
      $display("FAIL ack_gen_t2: gen_flag=%b expected 1", gen_flag);
      n_bad++;
    end
    tick();
  endtask

  task automatic test_range_and_midscan_reset;
    board_t exp;
    int     n;
    do_reset();
    land(12, 3, 4, 15, 2, 2, 7, 5, 1'b0);
    wait_gen(n);
    exp = '0;
    exp[2][2] = 1'b1; exp[7][5] = 1'b1;
    n_cmp++;
    if (arr !== exp || n != 13) begin
      $display("FAIL range_skip: arr=%h latency=%0d expected %h/13", arr, n, exp);
      n_bad++;
    end
    land(0, 0, 1, 0, 2, 0, 3, 0, 1'b0); wait_gen(n);
    land(4, 0, 5, 0, 6, 0, 7, 0, 1'b0); wait_gen(n);
    land(8, 0, 9, 0, 0, 1, 0, 1, 1'b0);
    n_cmp++;
    if (state !== 5'b01000) begin
      $display("FAIL midscan_in_scan: state=%b expected 01000", state);
      n_bad++;
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if (arr !== '0 || state !== 5'b00001 || lines !== 8'd0) begin
      $display("FAIL midscan_reset: arr=%h state=%b lines=%0d expected 0/00001/0", arr, state, lines);
      n_bad++;
    end
    tick();
    n_cmp++;
    if (gen_flag !== 1'b1) begin
      $display("FAIL midscan_restart_gen: gen_flag=%b expected 1", gen_flag);
      n_bad++;
    end
  endtask

  initial begin
    Reset = 1'b1;
    bottom_flag = 1'b0;
    top_flag = 1'b0;
    Ack = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    x3 = '0; y3 = '0; x4 = '0; y4 = '0;
    test_reset();
    test_simple_land();
    test_ack_ignored();
    test_one_clear();
    test_two_clear();
    test_top_out();
    test_range_and_midscan_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
